pdua_bus_bridge: RTL and testbench
==================================

# pdua_bus_bridge

Multi-channel memory/I/O bridge for the PDUA processor. It replaces the single-cycle `iom` steering between data RAM and one peripheral port with a registered transaction engine. The engine supports `N_PER` peripheral channels, each with a request/acknowledge handshake, and a timeout that returns an error instead of hanging the CPU. It sits between the processor's data/address buses and the RAM plus peripheral ports.

## Interface
- `DATA_WIDTH`, default 8: data bus width.
- `ADDR_WIDTH`, default 8: address bus width.
- `N_PER`, default 4: number of peripheral channels.
  - Power of two, ≥2, with `CH_BITS = log2(N_PER)`.
  - `CH_BITS < ADDR_WIDTH`.
- `TIMEOUT`, default 15: maximum peripheral wait cycles, ≥1.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `cpu_req`  in  1  transaction request; sampled only in IDLE.
- `cpu_wr_rdn`  in  1  1 = write, 0 = read.
- `cpu_iom`  in  1  0 = RAM, 1 = peripheral space.
- `cpu_addr`  in  ADDR_WIDTH  address.
- `cpu_wr_data`  in  DATA_WIDTH  write data.
- `cpu_rd_data`  out  DATA_WIDTH  registered read data; valid while `cpu_ready`=1.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `cpu_err`  out  1  with `cpu_ready`: peripheral timeout.
- `ram_wr_en`  out  1  RAM write strobe.
- `ram_addr`  out  ADDR_WIDTH  RAM address.
- `ram_wr_data`  out  DATA_WIDTH  RAM write data.
- `ram_rd_data`  in  DATA_WIDTH  RAM synchronous read data, valid the cycle after the address is presented.
- `per_sel`  out  N_PER  one-hot channel select; held until ack or timeout.
- `per_wr_rdn`, `per_addr`, `per_wr_data`  out  1/ADDR_WIDTH/DATA_WIDTH  peripheral command.
- `per_rd_data`  in  N_PER*DATA_WIDTH  packed read data; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `per_ack`  in  N_PER  per-channel acknowledge.

## Operation
- States: IDLE, RAM_ACC, RAM_CAP, PER_WAIT, RESP.
- **IDLE**
  - On `cpu_req`=1, register `cpu_wr_rdn`, `cpu_iom`, `cpu_addr` and `cpu_wr_data`.
  - Channel `ch = cpu_addr[ADDR_WIDTH-1 -: CH_BITS]`.
  - Next state is RAM_ACC if `iom`=0, otherwise PER_WAIT.
- **RAM_ACC**
  - Drives the registered address and data on the RAM port.
  - `ram_wr_en` = registered `wr_rdn`.
  - Next state: RAM_CAP.
- **RAM_CAP**
  - `ram_wr_en`=0.
  - On a read, capture `ram_rd_data` into `cpu_rd_data`; on a write, `cpu_rd_data` is unchanged.
  - Next state: RESP.
- **PER_WAIT**
  - `per_sel` = one-hot(ch); command outputs are driven from the registers.
  - The wait counter is cleared on entry and increments each cycle.
  - If `per_ack[ch]`=1: on a read, capture channel ch's data; next state RESP with err=0.
  - Otherwise, if the counter reaches `TIMEOUT`: next state RESP with err=1, and `cpu_rd_data` is loaded with all ones.
  - An ack in the same cycle as the timeout wins; err=0.
  - `per_ack` bits of non-selected channels are ignored.
- **RESP**
  - `cpu_ready`=1 and `cpu_err` = captured err, for exactly one cycle.
  - Next state: IDLE.
- `cpu_req` outside IDLE is ignored; there is no queuing.
- Outside PER_WAIT, `per_sel`=0. Outside RAM_ACC, `ram_wr_en`=0.
- Address and data outputs hold the last registered values.
- Counter width is `clog2(TIMEOUT+1)`; the counter saturates and never wraps.

## Timing
- Reset (`rst`=0 at a rising edge) sets:
  - state to IDLE;
  - `cpu_ready`, `cpu_err`, `ram_wr_en`, `per_sel` and `per_wr_rdn` to 0;
  - `cpu_rd_data`, `ram_addr`, `ram_wr_data`, `per_addr`, `per_wr_data` and the wait counter to 0.
- Reset mid-transaction aborts it: no `cpu_ready`, and `per_sel` drops at that edge.
- Request sampled in cycle 0 (IDLE):
  - RAM access: RAM_ACC in cycle 1, RAM_CAP in cycle 2, `cpu_ready` in cycle 3.
  - Peripheral access: PER_WAIT from cycle 1. Ack in cycle 1+d gives `cpu_ready` in cycle 2+d.
  - Timeout: no ack during cycles 1..TIMEOUT gives `cpu_ready`/`cpu_err` in cycle TIMEOUT+1.
- Back-to-back: the earliest next request is sampled in the cycle after RESP.
  - Best-case throughput is one RAM transaction per 4 cycles.
  - Best-case throughput is one peripheral transaction per 3 cycles.
- All outputs are registered or decoded from state only; there is no combinational path from `cpu_*` or `per_ack` to any output.

## Test plan
- **RAM write then read:** write 0xA5 to addr 0x10, then read 0x10.
  - `ram_wr_en` is high only in cycle 1 of the write.
  - The read gives `cpu_ready` in cycle 3 with `cpu_rd_data`=0xA5 and `cpu_err`=0.
- **Peripheral read, channel 2:** read addr 0x80 with `per_ack[2]` raised 3 cycles after `per_sel`=0100 and channel 2 data = 0x3C.
  - `cpu_ready` in cycle 5, `cpu_rd_data`=0x3C, err=0.
- **Timeout:** peripheral write to channel 1 with no ack.
  - `per_sel`=0010 for cycles 1..15.
  - `cpu_ready`=`cpu_err`=1 in cycle 16, `cpu_rd_data`=0xFF.
- **Wrong-channel ack:** channel 0 selected, ack only on `per_ack[3]` for 5 cycles, then `per_ack[0]`.
  - Completion follows `per_ack[0]` only.
- **Ack on the final timeout cycle:** ack in cycle 15 gives `cpu_ready` in cycle 16 with err=0.
- **Reset mid-PER_WAIT:** assert `rst`=0 in cycle 4.
  - State is IDLE, `per_sel`=0 and all outputs are 0 from that edge.
  - No `cpu_ready` pulse.
  - The next RAM read completes normally.

Source files
------------

// File: rtl/pdua_bus_bridge.sv
// Registered RAM / multi-channel peripheral bridge for the PDUA data bus.
// One transaction at a time; a stalled peripheral is cut off after TIMEOUT cycles.
module pdua_bus_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int N_PER      = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_req,
  input  logic                        cpu_wr_rdn,
  input  logic                        cpu_iom,
  input  logic [ADDR_WIDTH-1:0]       cpu_addr,
  input  logic [DATA_WIDTH-1:0]       cpu_wr_data,
  output logic [DATA_WIDTH-1:0]       cpu_rd_data,
  output logic                        cpu_ready,
  output logic                        cpu_err,
  output logic                        ram_wr_en,
  output logic [ADDR_WIDTH-1:0]       ram_addr,
  output logic [DATA_WIDTH-1:0]       ram_wr_data,
  input  logic [DATA_WIDTH-1:0]       ram_rd_data,
  output logic [N_PER-1:0]            per_sel,
  output logic                        per_wr_rdn,
  output logic [ADDR_WIDTH-1:0]       per_addr,
  output logic [DATA_WIDTH-1:0]       per_wr_data,
  input  logic [N_PER*DATA_WIDTH-1:0] per_rd_data,
  input  logic [N_PER-1:0]            per_ack
);

  localparam int CH_BITS = $clog2(N_PER);
  localparam int CNT_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RAM_ACC  = 3'd1,
    RAM_CAP  = 3'd2,
    PER_WAIT = 3'd3,
    RESP     = 3'd4
  } state_t;

  function automatic logic [N_PER-1:0] onehot(input logic [CH_BITS-1:0] idx);
    onehot = {{(N_PER-1){1'b0}}, 1'b1} << idx;
  endfunction

  state_t                  state_r, state_s;
  logic                    wr_rdn_r, wr_rdn_s;
  logic [CH_BITS-1:0]      ch_r, ch_s;
  logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
  logic [DATA_WIDTH-1:0]   wr_data_r, wr_data_s;
  logic [DATA_WIDTH-1:0]   rd_data_r, rd_data_s;
  logic                    ready_r, ready_s;
  logic                    err_r, err_s;
  logic                    ram_we_r, ram_we_s;
  logic [N_PER-1:0]        per_sel_r, per_sel_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic [CNT_W-1:0]        cnt_inc_s;

  // Next-state and next-value logic for every register of the bridge.
  always_comb begin
    state_s   = state_r;
    wr_rdn_s  = wr_rdn_r;
    ch_s      = ch_r;
    addr_s    = addr_r;
    wr_data_s = wr_data_r;
    rd_data_s = rd_data_r;
    ready_s   = 1'b0;
    err_s     = 1'b0;
    ram_we_s  = 1'b0;
    per_sel_s = '0;
    cnt_s     = cnt_r;
    // Saturating increment: the count reaching TIMEOUT marks the last wait cycle.
    if (cnt_r == CNT_W'(TIMEOUT)) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + CNT_W'(1);
    end

    case (state_r)
      IDLE: begin
        if (cpu_req) begin
          wr_rdn_s  = cpu_wr_rdn;
          addr_s    = cpu_addr;
          wr_data_s = cpu_wr_data;
          ch_s      = cpu_addr[ADDR_WIDTH-1 -: CH_BITS];
          cnt_s     = '0;
          if (cpu_iom) begin
            state_s   = PER_WAIT;
            per_sel_s = onehot(ch_s);
          end else begin
            state_s  = RAM_ACC;
            ram_we_s = cpu_wr_rdn;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RAM_ACC: begin
        state_s = RAM_CAP;
      end
      RAM_CAP: begin
        if (!wr_rdn_r) begin
          rd_data_s = ram_rd_data;
        end else begin
          rd_data_s = rd_data_r;
        end
        ready_s = 1'b1;
        state_s = RESP;
      end
      PER_WAIT: begin
        cnt_s = cnt_inc_s;
        if (per_ack[ch_r]) begin
          if (!wr_rdn_r) begin
            rd_data_s = per_rd_data[int'(ch_r)*DATA_WIDTH +: DATA_WIDTH];
          end else begin
            rd_data_s = rd_data_r;
          end
          ready_s = 1'b1;
          state_s = RESP;
        end else if (cnt_inc_s == CNT_W'(TIMEOUT)) begin
          rd_data_s = '1;
          ready_s   = 1'b1;
          err_s     = 1'b1;
          state_s   = RESP;
        end else begin
          per_sel_s = per_sel_r;
          state_s   = PER_WAIT;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      wr_rdn_r  <= 1'b0;
      ch_r      <= '0;
      addr_r    <= '0;
      wr_data_r <= '0;
      rd_data_r <= '0;
      ready_r   <= 1'b0;
      err_r     <= 1'b0;
      ram_we_r  <= 1'b0;
      per_sel_r <= '0;
      cnt_r     <= '0;
    end else begin
      state_r   <= state_s;
      wr_rdn_r  <= wr_rdn_s;
      ch_r      <= ch_s;
      addr_r    <= addr_s;
      wr_data_r <= wr_data_s;
      rd_data_r <= rd_data_s;
      ready_r   <= ready_s;
      err_r     <= err_s;
      ram_we_r  <= ram_we_s;
      per_sel_r <= per_sel_s;
      cnt_r     <= cnt_s;
    end
  end

  assign cpu_rd_data = rd_data_r;
  assign cpu_ready   = ready_r;
  assign cpu_err     = err_r;
  assign ram_wr_en   = ram_we_r;
  assign ram_addr    = addr_r;
  assign ram_wr_data = wr_data_r;
  assign per_sel     = per_sel_r;
  assign per_wr_rdn  = wr_rdn_r;
  assign per_addr    = addr_r;
  assign per_wr_data = wr_data_r;

endmodule

// File: tb/tb_pdua_bus_bridge.sv
// Self-checking bench for pdua_bus_bridge: directed scenarios plus randomized
// RAM/peripheral traffic checked against a transaction-level reference model.
module tb_pdua_bus_bridge;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int NP = 4;
  localparam int TO = 15;

  logic          clk;
  logic          rst;
  logic          cpu_req;
  logic          cpu_wr_rdn;
  logic          cpu_iom;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wr_data;
  logic [DW-1:0] cpu_rd_data;
  logic          cpu_ready;
  logic          cpu_err;
  logic          ram_wr_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data;
  logic [DW-1:0] ram_rd_data;
  logic [NP-1:0] per_sel;
  logic          per_wr_rdn;
  logic [AW-1:0] per_addr;
  logic [DW-1:0] per_wr_data;
  logic [NP*DW-1:0] per_rd_data;
  logic [NP-1:0] per_ack;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] ram_mem [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_rd;
  logic [AW-1:0] pool [8];

  pdua_bus_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_PER(NP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr_rdn(cpu_wr_rdn), .cpu_iom(cpu_iom),
    .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_rd_data(cpu_rd_data), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data),
    .per_sel(per_sel), .per_wr_rdn(per_wr_rdn), .per_addr(per_addr),
    .per_wr_data(per_wr_data), .per_rd_data(per_rd_data), .per_ack(per_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM attached to the bridge.
  always @(posedge clk) begin
    if (ram_wr_en) ram_mem[ram_addr] <= ram_wr_data;
    ram_rd_data <= ram_mem[ram_addr];
  end

  task automatic junk_cpu(input logic allow_req);
    cpu_req     = allow_req ? 1'($urandom) : 1'b0;
    cpu_wr_rdn  = 1'($urandom);
    cpu_iom     = 1'($urandom);
    cpu_addr    = 8'($urandom);
    cpu_wr_data = 8'($urandom);
  endtask

  // One RAM transaction; request sampled at the end of cycle 0, ready in cycle 3.
  task automatic do_ram(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    logic [DW-1:0] exp;
    exp = wr ? exp_rd : ref_mem[addr];
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr_rdn = wr; cpu_iom = 1'b0; cpu_addr = addr; cpu_wr_data = wdata;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (c == 1) begin
        if (ram_wr_en !== wr || ram_addr !== addr || ram_wr_data !== wdata ||
            cpu_ready !== 1'b0 || per_sel !== 4'b0000) begin
          n_fail++;
          $display("FAIL ram_acc: we=%b addr=%h wd=%h rdy=%b sel=%b required we=%b addr=%h wd=%h rdy=0 sel=0000",
                   ram_wr_en, ram_addr, ram_wr_data, cpu_ready, per_sel, wr, addr, wdata);
        end
      end else if (c == 2) begin
        if (ram_wr_en !== 1'b0 || cpu_ready !== 1'b0 || per_sel !== 4'b0000) begin
          n_fail++;
          $display("FAIL ram_cap: we=%b rdy=%b sel=%b required we=0 rdy=0 sel=0000",
                   ram_wr_en, cpu_ready, per_sel);
        end
      end else begin
        if (cpu_ready !== 1'b1 || cpu_err !== 1'b0 || cpu_rd_data !== exp || ram_wr_en !== 1'b0) begin
          n_fail++;
          $display("FAIL ram_resp: rdy=%b err=%b data=%h we=%b required rdy=1 err=0 data=%h we=0",
                   cpu_ready, cpu_err, cpu_rd_data, ram_wr_en, exp);
        end
      end
      junk_cpu(c < 3);
    end
    if (wr) ref_mem[addr] = wdata;
    exp_rd = exp;
  endtask

  // One peripheral transaction. ack_cyc: cycle (1-based in PER_WAIT) the selected
  // channel acks, 0 for never. noise: acks on other channels until then.
  task automatic do_per(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int ack_cyc, input logic [NP-1:0] noise);
    int            ch;
    int            done;
    logic          ok;
    logic          exp_err;
    logic [DW-1:0] exp;
    logic [NP-1:0] sel;
    logic [NP-1:0] ack;
    ch      = int'(addr[AW-1 -: 2]);
    sel     = 4'b0001 << ch;
    ok      = (ack_cyc >= 1) && (ack_cyc <= TO);
    done    = ok ? ack_cyc + 1 : TO + 1;
    exp_err = !ok;
    if (!ok) exp = 8'hFF;
    else if (wr) exp = exp_rd;
    else exp = per_rd_data[ch*DW +: DW];
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr_rdn = wr; cpu_iom = 1'b1; cpu_addr = addr; cpu_wr_data = wdata;
    for (int c = 1; c <= done; c++) begin
      @(negedge clk);
      n_tests++;
      if (c < done) begin
        if (cpu_ready !== 1'b0 || per_sel !== sel || per_addr !== addr || per_wr_rdn !== wr ||
            per_wr_data !== wdata || ram_wr_en !== 1'b0) begin
          n_fail++;
          $display("FAIL per_wait c=%0d: rdy=%b sel=%b addr=%h wr=%b wd=%h required rdy=0 sel=%b addr=%h wr=%b wd=%h",
                   c, cpu_ready, per_sel, per_addr, per_wr_rdn, per_wr_data, sel, addr, wr, wdata);
        end
      end else begin
        if (cpu_ready !== 1'b1 || cpu_err !== exp_err || cpu_rd_data !== exp || per_sel !== 4'b0000) begin
          n_fail++;
          $display("FAIL per_resp c=%0d: rdy=%b err=%b data=%h sel=%b required rdy=1 err=%b data=%h sel=0000",
                   c, cpu_ready, cpu_err, cpu_rd_data, per_sel, exp_err, exp);
        end
      end
      junk_cpu(c < done);
      ack = '0;
      if (c < done) begin
        if (c == ack_cyc) ack = sel;
        else if (ack_cyc == 0 || c < ack_cyc) ack = noise & ~sel;
        else ack = '0;
      end
      per_ack = ack;
    end
    per_ack = '0;
    exp_rd  = exp;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    junk_cpu(1'b1);
    cpu_req = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({cpu_rd_data, cpu_ready, cpu_err, ram_wr_en, ram_addr, ram_wr_data, per_sel,
         per_wr_rdn, per_addr, per_wr_data} !== 48'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: rd=%h rdy=%b err=%b we=%b ra=%h rwd=%h sel=%b pwr=%b pa=%h pwd=%h required all zero",
               cpu_rd_data, cpu_ready, cpu_err, ram_wr_en, ram_addr, ram_wr_data, per_sel,
               per_wr_rdn, per_addr, per_wr_data);
    end
    rst = 1'b1;
    cpu_req = 1'b0;
    exp_rd = 8'h00;
  endtask

  task automatic test_ram_wr_rd;
    do_ram(1'b1, 8'h10, 8'hA5);
    do_ram(1'b0, 8'h10, 8'h00);
  endtask

  task automatic test_per_read_ch2;
    per_rd_data = $urandom;
    per_rd_data[23:16] = 8'h3C;
    do_per(1'b0, 8'h80, 8'h00, 4, 4'b0000);
  endtask

  task automatic test_timeout;
    do_per(1'b1, 8'h47, 8'h5A, 0, 4'b0000);
  endtask

  task automatic test_wrong_channel;
    per_rd_data = $urandom;
    do_per(1'b0, 8'h05, 8'h00, 6, 4'b1000);
  endtask

  task automatic test_ack_last_cycle;
    per_rd_data = $urandom;
    do_per(1'b0, 8'hC3, 8'h00, TO, 4'b0000);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr_rdn = 1'b0; cpu_iom = 1'b1; cpu_addr = 8'h40; cpu_wr_data = 8'h00;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      cpu_req = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({cpu_rd_data, cpu_ready, cpu_err, ram_wr_en, ram_addr, ram_wr_data, per_sel,
         per_wr_rdn, per_addr, per_wr_data} !== 48'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: rd=%h rdy=%b sel=%b pa=%h required all zero",
               cpu_rd_data, cpu_ready, per_sel, per_addr);
    end
    rst = 1'b1;
    exp_rd = 8'h00;
    for (int c = 0; c < TO + 5; c++) begin
      @(negedge clk);
      n_tests++;
      if (cpu_ready !== 1'b0 || per_sel !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_mid_quiet c=%0d: rdy=%b sel=%b required rdy=0 sel=0000", c, cpu_ready, per_sel);
      end
    end
    do_ram(1'b0, 8'h10, 8'h00);
  endtask

  task automatic test_back_to_back;
    per_rd_data = $urandom;
    do_per(1'b0, 8'h81, 8'h00, 1, 4'b0000);
    do_per(1'b1, 8'hC2, 8'h77, 1, 4'b0000);
    do_ram(1'b1, 8'h20, 8'h9C);
    do_ram(1'b0, 8'h20, 8'h00);
    do_per(1'b0, 8'h3F, 8'h00, 1, 4'b0000);
    do_ram(1'b0, 8'h10, 8'h00);
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      pool[i] = 8'($urandom);
      do_ram(1'b1, pool[i], 8'($urandom));
    end
    for (int i = 0; i < 60; i++) begin
      if (($urandom % 2) == 0) begin
        do_ram(1'($urandom), pool[$urandom % 8], 8'($urandom));
      end else begin
        per_rd_data = $urandom;
        do_per(1'($urandom), 8'($urandom), 8'($urandom), int'($urandom % (TO + 3)), 4'($urandom));
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;
    per_ack = '0;
    per_rd_data = '0;
    cpu_req = 1'b0; cpu_wr_rdn = 1'b0; cpu_iom = 1'b0; cpu_addr = '0; cpu_wr_data = '0;
    rst = 1'b0;
    exp_rd = 8'h00;
    test_reset;
    test_ram_wr_rd;
    test_per_read_ch2;
    test_timeout;
    test_wrong_channel;
    test_ack_last_cycle;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
